// File: rtl/matrix_writer.sv
// Store side of the matrix BRAM: writes a header word plus a row-major element
// stream into one matrix slot, zero-padding the tail if the source stops early.
module matrix_writer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_DIM    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            rows,
  input  logic [7:0]            cols,
  input  logic [31:0]           elem_data,
  input  logic                  elem_valid,
  output logic                  elem_ready,
  input  logic                  finish,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_din,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, CHECK, HDR, DATA, PAD, DONE} state_t;

  localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] base;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [15:0]           total;
  logic [15:0]           k;
  logic [15:0]           k_next;
  logic                  error_q;
  logic                  dims_bad;
  logic                  accept;
  logic                  last_elem;
  logic [ADDR_WIDTH-1:0] elem_addr;

  assign dims_bad  = (rows_q == 8'd0) || (cols_q == 8'd0) ||
                     (rows_q > MAX_DIM_B) || (cols_q > MAX_DIM_B);
  assign accept    = (state == DATA) && elem_valid;
  assign last_elem = (k == total - 16'd1);
  assign k_next    = k + {15'd0, accept};
  assign elem_addr = base + ADDR_WIDTH'(k) + ADDR_WIDTH'(1);
  assign error     = error_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // An element accepted in the same cycle as finish is counted before deciding to pad.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = CHECK;
      CHECK: next_state = dims_bad ? IDLE : HDR;
      HDR:   next_state = DATA;
      DATA: begin
        if (accept && last_elem)           next_state = DONE;
        else if (finish && k_next < total) next_state = PAD;
      end
      PAD:   if (last_elem) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base    <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      total   <= '0;
      k       <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= (state == CHECK) && dims_bad;
      case (state)
        IDLE: begin
          if (start) begin
            rows_q <= rows;
            cols_q <= cols;
            base   <= ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
          end
        end
        CHECK: begin
          total <= {8'd0, rows_q} * {8'd0, cols_q};
          k     <= '0;
        end
        DATA:    if (accept) k <= k + 16'd1;
        PAD:     k <= k + 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    elem_ready = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_din   = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      HDR: begin
        bram_we   = 1'b1;
        bram_addr = base;
        bram_din  = {16'h0, rows_q, cols_q};
      end
      DATA: begin
        elem_ready = 1'b1;
        if (elem_valid) begin
          bram_we   = 1'b1;
          bram_addr = elem_addr;
          bram_din  = elem_data;
        end
      end
      PAD: begin
        bram_we   = 1'b1;
        bram_addr = elem_addr;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_writer.sv
// Scoreboard bench for matrix_writer: expected BRAM writes are queued when a
// scenario starts and checked in order as the DUT issues them.
module tb_matrix_writer;

  typedef struct packed {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  matrix_id;
  logic [7:0]  rows;
  logic [7:0]  cols;
  logic [31:0] elem_data;
  logic        elem_valid;
  logic        elem_ready;
  logic        finish;
  logic        bram_we;
  logic [13:0] bram_addr;
  logic [31:0] bram_din;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;
  int writes   = 0;
  wr_t sb[$];
  logic [31:0] vals [0:1023];

  matrix_writer dut (
    .clk(clk), .rst(rst), .start(start), .matrix_id(matrix_id),
    .rows(rows), .cols(cols), .elem_data(elem_data), .elem_valid(elem_valid),
    .elem_ready(elem_ready), .finish(finish), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  // Every write is popped against the queue in order; a write with nothing queued is an error.
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      wr_t exp;
      writes++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write addr=%0d din=%h (no write expected)", bram_addr, bram_din);
      end else begin
        exp = sb.pop_front();
        if (bram_addr !== exp.a || bram_din !== exp.d) begin
          failures++;
          $display("[TB] FAIL bram_write got addr=%0d din=%h, expected addr=%0d din=%h",
                   bram_addr, bram_din, exp.a, exp.d);
        end
      end
    end
  end

  task automatic push_slot(input int id, input int r, input int c, input int n);
    int base;
    base = id * 1152;
    sb.push_back('{a: 14'(base), d: {16'h0, 8'(r), 8'(c)}});
    for (int i = 0; i < r * c; i++)
      sb.push_back('{a: 14'(base + 1 + i), d: (i < n) ? vals[i] : 32'h0});
  endtask

  // Drives one start and feeds n elements (optionally every other cycle, optionally followed by finish).
  task automatic run_write(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                           input int n, input bit toggle, input bit use_finish,
                           input int restart_t, input int budget,
                           output int done_t, output int err_t, output int ready_bad);
    int idx;
    int fin_t;
    bit hs;
    idx = 0; hs = 0; fin_t = budget + 10;
    done_t = -1; err_t = -1; ready_bad = 0;
    @(posedge clk); #1;
    matrix_id = id; rows = r; cols = c; start = 1'b1; elem_valid = 1'b0; finish = 1'b0;
    for (int t = 1; t <= budget; t++) begin
      @(posedge clk); #1;
      start = (t == restart_t);
      if (t == restart_t) matrix_id = id ^ 3'b100;
      if (hs) idx++;
      finish = 1'b0;
      if (use_finish && idx == n && fin_t > budget) begin
        finish = 1'b1;
        fin_t  = t;
      end
      elem_valid = (idx < n) && (!toggle || (t % 2 == 1));
      elem_data  = (idx < n) ? vals[idx] : 32'h0;
      @(negedge clk);
      hs = elem_ready && elem_valid;
      if (elem_ready && (t < 3 || t > fin_t || done || !busy)) ready_bad++;
      if (error && err_t < 0) err_t = t;
      if (done) begin
        done_t = t;
        break;
      end
      if (err_t >= 0) break;
    end
    @(posedge clk); #1;
    start = 1'b0; elem_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; matrix_id = '0; rows = '0; cols = '0;
    elem_data = '0; elem_valid = 1'b0; finish = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, error, bram_we, elem_ready, bram_addr, bram_din} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b error=%b we=%b ready=%b addr=%0d din=%h, expected all 0",
               busy, done, error, bram_we, elem_ready, bram_addr, bram_din);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int dt, et, rb;
    for (int i = 0; i < 6; i++) vals[i] = 32'(i + 1);
    push_slot(2, 2, 3, 6);
    run_write(3'd2, 8'd2, 8'd3, 6, 1'b0, 1'b0, 0, 40, dt, et, rb);
    checks++;
    if (dt !== 9) begin
      failures++;
      $display("[TB] FAIL b2b_done_latency got %0d, expected 9", dt);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL b2b_pending_writes got %0d left, expected 0", sb.size());
    end
  endtask

  task automatic test_throttled();
    int dt, et, rb, w0;
    for (int i = 0; i < 9; i++) vals[i] = 32'hC0DE_0000 + 32'(i * 7);
    push_slot(0, 3, 3, 9);
    w0 = writes;
    run_write(3'd0, 8'd3, 8'd3, 9, 1'b1, 1'b0, 0, 60, dt, et, rb);
    checks++;
    if (writes - w0 !== 10) begin
      failures++;
      $display("[TB] FAIL throttled_write_count got %0d, expected 10", writes - w0);
    end
    checks++;
    if (rb !== 0) begin
      failures++;
      $display("[TB] FAIL throttled_ready_outside_data got %0d cycles, expected 0", rb);
    end
    checks++;
    if (dt !== 20) begin
      failures++;
      $display("[TB] FAIL throttled_done_latency got %0d, expected 20", dt);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL throttled_pending_writes got %0d left, expected 0", sb.size());
    end
  endtask

  task automatic test_finish_pad();
    int dt, et, rb;
    vals[0] = 32'hFFFF_FFF9;
    vals[1] = 32'h1234_5678;
    push_slot(7, 2, 2, 2);
    run_write(3'd7, 8'd2, 8'd2, 2, 1'b0, 1'b1, 0, 40, dt, et, rb);
    checks++;
    if (dt !== 8) begin
      failures++;
      $display("[TB] FAIL pad_done_latency got %0d, expected 8", dt);
    end
    checks++;
    if (rb !== 0) begin
      failures++;
      $display("[TB] FAIL pad_ready_in_pad got %0d cycles, expected 0", rb);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL pad_pending_writes got %0d left, expected 0", sb.size());
    end
  endtask

  task automatic test_illegal();
    int dt, et, rb, w0;
    logic [7:0] rs [2];
    logic [7:0] cs [2];
    rs[0] = 8'd0; cs[0] = 8'd3;
    rs[1] = 8'd2; cs[1] = 8'd33;
    for (int i = 0; i < 2; i++) begin
      w0 = writes;
      run_write(3'd5, rs[i], cs[i], 0, 1'b0, 1'b0, 0, 8, dt, et, rb);
      checks++;
      if (et !== 2 || dt !== -1) begin
        failures++;
        $display("[TB] FAIL illegal_error_timing case %0d got err_t=%0d done_t=%0d, expected 2 and -1", i, et, dt);
      end
      checks++;
      if (writes - w0 !== 0) begin
        failures++;
        $display("[TB] FAIL illegal_writes case %0d got %0d, expected 0", i, writes - w0);
      end
      @(negedge clk);
      checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL illegal_after case %0d got error=%b busy=%b, expected 0 0", i, error, busy);
      end
    end
  endtask

  task automatic test_full();
    int dt, et, rb;
    for (int i = 0; i < 1024; i++) vals[i] = $urandom;
    push_slot(1, 32, 32, 1024);
    run_write(3'd1, 8'd32, 8'd32, 1024, 1'b0, 1'b0, 100, 1100, dt, et, rb);
    checks++;
    if (dt !== 1027) begin
      failures++;
      $display("[TB] FAIL full_done_latency got %0d, expected 1027", dt);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL full_pending_writes got %0d left, expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_idle_after got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int dt, et, rb;
    sb.push_back('{a: 14'd3456, d: 32'h0000_0202});
    sb.push_back('{a: 14'd3457, d: 32'hA000_0003});
    sb.push_back('{a: 14'd3458, d: 32'hA000_0004});
    @(posedge clk); #1;
    matrix_id = 3'd3; rows = 8'd2; cols = 8'd2; start = 1'b1; elem_valid = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      elem_data = 32'hA000_0000 + 32'(t);
      rst = (t == 4);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bram_we !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got busy=%b we=%b done=%b, expected 0 0 0", busy, bram_we, done);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL midreset_pending_writes got %0d left, expected 0", sb.size());
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; elem_valid = 1'b0;
    vals[0] = 32'h8000_0001;
    push_slot(4, 1, 1, 1);
    run_write(3'd4, 8'd1, 8'd1, 1, 1'b0, 1'b0, 0, 20, dt, et, rb);
    checks++;
    if (dt !== 4) begin
      failures++;
      $display("[TB] FAIL after_reset_done_latency got %0d, expected 4", dt);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL after_reset_pending_writes got %0d left, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_throttled();
    test_finish_pad();
    test_illegal();
    test_full();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
